// File: rtl/eros_obi_error_responder.sv
// eros_obi_error_responder
// OBI slave that accepts every request immediately and answers each one,
// LATENCY cycles later, with an error response carrying ERR_RDATA.
// Optional error log (count plus first failing address/direction) is built
// only when the macro EROS_ERR_RESP_LOG_EN is defined; otherwise the log
// outputs are tied to zero and no log flops exist.
//
// Handshake semantics: req_i is the request-valid, gnt_o is the ready.
// A transfer happens in every cycle where req_i && gnt_o is high. Because
// gnt_o mirrors req_i, every presented request is accepted in the same
// cycle. The response phase has no back-pressure: rvalid_o is a one-cycle
// pulse per accepted request, in request order.

module eros_obi_error_responder #(
    parameter int unsigned LATENCY   = 1,
    parameter logic [31:0] ERR_RDATA = 32'hBADACCE5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic        clear_i,
    output logic [15:0] err_count_o,
    output logic [31:0] first_addr_o,
    output logic        first_we_o,
    output logic        first_vld_o
);

    // ------------------------------------------------------------------
    // Request side
    // ------------------------------------------------------------------
    logic handshake;

    // Grant follows request with no wait states, including during reset.
    always_comb begin
        gnt_o     = req_i;
        handshake = req_i && gnt_o;
    end

    // ------------------------------------------------------------------
    // Response pipeline: one token per accepted request, shifted towards
    // rvalid_o. Bit 0 is loaded in the handshake cycle, so the token
    // reaches bit LATENCY-1 exactly LATENCY cycles after the grant.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0] pipe_q;

    generate
        if (LATENCY == 1) begin : g_pipe_single
            // Single-stage pipeline: the token is visible the cycle after the grant.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= handshake;
                end
            end
        end else begin : g_pipe_multi
            // Multi-stage pipeline: shift tokens one stage per cycle.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    pipe_q <= '0;
                end else begin
                    pipe_q <= {pipe_q[LATENCY-2:0], handshake};
                end
            end
        end
    endgenerate

    // Every response is an error response; data is only driven while valid.
    always_comb begin
        rvalid_o = pipe_q[LATENCY-1];
        err_o    = rvalid_o;
        rdata_o  = rvalid_o ? ERR_RDATA : 32'h0;
    end

`ifdef EROS_ERR_RESP_LOG_EN
    // ------------------------------------------------------------------
    // Error log. A clear coinciding with a handshake is applied first, so
    // the coinciding request becomes the first entry of the fresh log.
    // Reset holds the log at zero, so handshakes during reset are dropped.
    // ------------------------------------------------------------------
    logic [15:0] count_q, count_d;
    logic [31:0] first_addr_q, first_addr_d;
    logic        first_we_q, first_we_d;
    logic        first_vld_q, first_vld_d;

    // Next log state: optional clear, then saturating count and first capture.
    always_comb begin
        count_d      = count_q;
        first_addr_d = first_addr_q;
        first_we_d   = first_we_q;
        first_vld_d  = first_vld_q;
        if (clear_i) begin
            count_d      = 16'h0;
            first_addr_d = 32'h0;
            first_we_d   = 1'b0;
            first_vld_d  = 1'b0;
        end
        if (handshake) begin
            if (count_d != 16'hFFFF) begin
                count_d = count_d + 16'd1;
            end
            if (!first_vld_d) begin
                first_vld_d  = 1'b1;
                first_addr_d = addr_i;
                first_we_d   = we_i;
            end
        end
    end

    // Log registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q      <= 16'h0;
            first_addr_q <= 32'h0;
            first_we_q   <= 1'b0;
            first_vld_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            first_addr_q <= first_addr_d;
            first_we_q   <= first_we_d;
            first_vld_q  <= first_vld_d;
        end
    end

    // Expose the log.
    always_comb begin
        err_count_o  = count_q;
        first_addr_o = first_addr_q;
        first_we_o   = first_we_q;
        first_vld_o  = first_vld_q;
    end

    // Write payload never influences any state.
    logic unused_payload;
    assign unused_payload = ^{be_i, wdata_i};
`else
    // Log absent: outputs tied off, log inputs have no effect.
    always_comb begin
        err_count_o  = 16'h0;
        first_addr_o = 32'h0;
        first_we_o   = 1'b0;
        first_vld_o  = 1'b0;
    end

    logic unused_inputs;
    assign unused_inputs = ^{be_i, wdata_i, addr_i, we_i, clear_i};
`endif

endmodule

// File: tb/tb_eros_obi_error_responder.sv
// Bench for eros_obi_error_responder. Three instances (LATENCY 1, 2, 3)
// share one stimulus stream. A reference model records handshake cycles in
// a queue and derives each instance's expected response cycle from it; the
// log is modelled as plain counters. Directed scenarios pin exact values.
// Log checks follow EROS_ERR_RESP_LOG_EN: with the macro undefined the log
// outputs must stay zero.

module tb_eros_obi_error_responder;

`ifdef EROS_ERR_RESP_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif
    localparam logic [31:0] ERR = 32'hBADACCE5;

    // ---------------- clock / reset / stimulus signals ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [3:0]  be = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic        clear = 1'b0;

    logic [2:0]  gnt, rvalid, err, first_we, first_vld;
    logic [31:0] rdata [3];
    logic [31:0] first_addr [3];
    logic [15:0] cnt [3];

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        eros_obi_error_responder #(.LATENCY(k + 1), .ERR_RDATA(ERR)) u_dut (
            .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt[k]),
            .addr_i(addr), .we_i(we), .be_i(be), .wdata_i(wdata),
            .rvalid_o(rvalid[k]), .rdata_o(rdata[k]), .err_o(err[k]),
            .clear_i(clear), .err_count_o(cnt[k]),
            .first_addr_o(first_addr[k]), .first_we_o(first_we[k]),
            .first_vld_o(first_vld[k])
        );
    end

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (LATENCY=%0d) at t=%0t: got %h expected %h",
                     name, k + 1, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          hs_q[$];        // cycle numbers of accepted handshakes
    int          m_cnt = 0;
    logic [31:0] m_addr = 32'h0;
    logic        m_we = 1'b0;
    logic        m_vld = 1'b0;

    // Record what happened in the cycle that just ended.
    always @(posedge clk) begin
        cyc++;
        if (!rst) begin
            if (clear) begin
                m_cnt = 0; m_vld = 1'b0; m_addr = 32'h0; m_we = 1'b0;
            end
            if (req) begin
                hs_q.push_back(cyc);
                if (m_cnt < 65535) m_cnt++;
                if (!m_vld) begin
                    m_vld = 1'b1; m_addr = addr; m_we = we;
                end
            end
        end
    end

    // Compare every instance against the model each cycle.
    always @(negedge clk) begin
        logic exp_rv;
        if (rst) begin
            hs_q.delete();
            m_cnt = 0; m_vld = 1'b0; m_addr = 32'h0; m_we = 1'b0;
        end
        while (hs_q.size() > 0 && hs_q[0] + 4 <= cyc) void'(hs_q.pop_front());
        for (int k = 0; k < 3; k++) begin
            exp_rv = 1'b0;
            foreach (hs_q[j]) if (hs_q[j] + k == cyc) exp_rv = 1'b1;
            chk("gnt", k, 32'(gnt[k]), 32'(req));
            chk("rvalid", k, 32'(rvalid[k]), 32'(exp_rv));
            chk("err", k, 32'(err[k]), 32'(exp_rv));
            chk("rdata", k, rdata[k], exp_rv ? ERR : 32'h0);
            chk("err_count", k, 32'(cnt[k]), LOG_EN ? 32'(m_cnt) : 32'h0);
            chk("first_addr", k, first_addr[k], LOG_EN ? m_addr : 32'h0);
            chk("first_we", k, 32'(first_we[k]), LOG_EN ? 32'(m_we) : 32'h0);
            chk("first_vld", k, 32'(first_vld[k]), LOG_EN ? 32'(m_vld) : 32'h0);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic w, input logic [31:0] a,
                        input logic c, input logic rs);
        @(posedge clk);
        #1;
        req = r; we = w; addr = a; clear = c; rst = rs;
        be = 4'($urandom); wdata = $urandom;
    endtask

    task automatic all_zero(input string name);
        for (int k = 0; k < 3; k++) begin
            chk({name, " rvalid"}, k, 32'(rvalid[k]), 32'h0);
            chk({name, " err"}, k, 32'(err[k]), 32'h0);
            chk({name, " rdata"}, k, rdata[k], 32'h0);
            chk({name, " err_count"}, k, 32'(cnt[k]), 32'h0);
            chk({name, " first_addr"}, k, first_addr[k], 32'h0);
            chk({name, " first_we"}, k, 32'(first_we[k]), 32'h0);
            chk({name, " first_vld"}, k, 32'(first_vld[k]), 32'h0);
        end
    endtask

    initial begin
        // Reset state
        repeat (3) step(1'b1, 1'b0, 32'h1000, 1'b0, 1'b1);
        @(negedge clk);
        all_zero("reset");
        chk("gnt in reset", 0, 32'(gnt[0]), 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // LATENCY=1 single read
        step(1'b1, 1'b0, ERR, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat1 rvalid", 0, 32'(rvalid[0]), 32'h1);
        chk("lat1 err", 0, 32'(err[0]), 32'h1);
        chk("lat1 rdata", 0, rdata[0], 32'hBADACCE5);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("lat1 rvalid low", 0, 32'(rvalid[0]), 32'h0);
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

        // LATENCY=3 back-to-back burst of four
        for (int i = 0; i < 8; i++) begin
            step(i < 4, 1'b0, 32'h2000 + 32'(i * 4), 1'b0, 1'b0);
            @(negedge clk);
            chk("lat3 burst rvalid", 2, 32'(rvalid[2]), 32'((i >= 3) && (i <= 6)));
        end
        repeat (5) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

`ifdef EROS_ERR_RESP_LOG_EN
        // First-error capture
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 32'h50000000, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h60000000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("log count", 0, 32'(cnt[0]), 32'd2);
        chk("log first_addr", 0, first_addr[0], 32'h50000000);
        chk("log first_we", 0, 32'(first_we[0]), 32'h1);
        chk("log first_vld", 0, 32'(first_vld[0]), 32'h1);

        // Clear coinciding with a read
        step(1'b1, 1'b0, 32'h70000004, 1'b1, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("clear+req count", 0, 32'(cnt[0]), 32'd1);
        chk("clear+req first_addr", 0, first_addr[0], 32'h70000004);
        chk("clear+req first_we", 0, 32'(first_we[0]), 32'h0);
        chk("clear+req first_vld", 0, 32'(first_vld[0]), 32'h1);

        // Saturation
        step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        repeat (65534) step(1'b1, 1'b0, 32'h3000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("preload count", 1, 32'(cnt[1]), 32'h0000FFFE);
        repeat (3) step(1'b1, 1'b1, 32'h3004, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        chk("saturated count", 1, 32'(cnt[1]), 32'h0000FFFF);
        repeat (3) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
`endif

        // LATENCY=2: reset one cycle after a grant flushes the response
        step(1'b1, 1'b0, 32'h4000, 1'b0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post-reset lat2 rvalid", 1, 32'(rvalid[1]), 32'h0);
            all_zero("post-reset");
            step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        end

        // Randomized traffic, rare clears and resets
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom), $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
        end
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
